// File: rtl/jesd_sysref_lmfc.sv
// LMFC generator: synchronises SYSREF, aligns the multiframe counter to it and flags phase errors.
// Optional JESD_SYSREF_ERR_CNT_EN adds the sysref_err_cnt misaligned-edge counter port.
module jesd_sysref_lmfc #(
  parameter int unsigned LMFC_PERIOD   = 16,
  parameter int unsigned CNT_W         = 8,
  parameter int unsigned SYNC_STAGES   = 2,
  parameter int unsigned SYSREF_OFFSET = 0
) (
  input  logic             coreclk,
  input  logic             rst_n,
  input  logic             sysref,
  input  logic             capture_en,
  input  logic             sysref_continuous,
  input  logic             err_clr,
  output logic [CNT_W-1:0] lmfc_cnt,
  output logic             lmfc_pulse,
  output logic             aligned,
  output logic             sysref_err,
  output logic [7:0]       sysref_edge_cnt
`ifdef JESD_SYSREF_ERR_CNT_EN
  ,
  output logic [7:0]       sysref_err_cnt
`endif
);

  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(LMFC_PERIOD - 1);
  localparam logic [CNT_W-1:0] CNT_OFFSET = CNT_W'(SYSREF_OFFSET);

  typedef enum logic [1:0] {
    IDLE,
    ARMED,
    ALIGNED
  } state_t;

  state_t state, state_nxt;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_prev;
  logic                   edge_flag;
  logic [CNT_W-1:0]       cnt_inc;
  logic [CNT_W-1:0]       cnt_nxt;
  logic                   mismatch;
  logic                   load;
  logic                   err_set;

  always_ff @(posedge coreclk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q    <= '0;
      sync_prev <= 1'b0;
      edge_flag <= 1'b0;
    end else begin
      sync_q    <= {sync_q[SYNC_STAGES-2:0], sysref};
      sync_prev <= sync_q[SYNC_STAGES-1];
      edge_flag <= sync_q[SYNC_STAGES-1] & ~sync_prev;
    end
  end

  // Wrap by compare so non-power-of-two periods work.
  assign cnt_inc  = (lmfc_cnt == CNT_LAST) ? '0 : lmfc_cnt + CNT_W'(1);
  assign mismatch = (cnt_inc != CNT_OFFSET);

  always_ff @(posedge coreclk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    err_set   = 1'b0;
    // Dropping capture_en overrides any edge seen in the same cycle.
    if (!capture_en) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:  state_nxt = ARMED;
        ARMED: begin
          if (edge_flag) begin
            state_nxt = ALIGNED;
            load      = 1'b1;
          end
        end
        ALIGNED: begin
          if (edge_flag && mismatch) begin
            err_set = 1'b1;
            load    = sysref_continuous;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
    cnt_nxt = load ? CNT_OFFSET : cnt_inc;
  end

  always_ff @(posedge coreclk or negedge rst_n) begin
    if (!rst_n) begin
      lmfc_cnt        <= '0;
      lmfc_pulse      <= 1'b0;
      aligned         <= 1'b0;
      sysref_err      <= 1'b0;
      sysref_edge_cnt <= '0;
    end else begin
      lmfc_cnt   <= cnt_nxt;
      lmfc_pulse <= (cnt_nxt == '0);
      aligned    <= (state_nxt == ALIGNED);
      if (err_set)      sysref_err <= 1'b1;
      else if (err_clr) sysref_err <= 1'b0;
      if (edge_flag && (sysref_edge_cnt != '1))
        sysref_edge_cnt <= sysref_edge_cnt + 8'd1;
    end
  end

`ifdef JESD_SYSREF_ERR_CNT_EN
  always_ff @(posedge coreclk or negedge rst_n) begin
    if (!rst_n) begin
      sysref_err_cnt <= '0;
    end else if (err_clr) begin
      sysref_err_cnt <= err_set ? 8'd1 : 8'd0;
    end else if (err_set && (sysref_err_cnt != '1)) begin
      sysref_err_cnt <= sysref_err_cnt + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_jesd_sysref_lmfc.sv
// Directed bench for jesd_sysref_lmfc: reset, capture, in-phase/misaligned SYSREF,
// err_clr priority, capture_en drop and edge-counter saturation.
module tb_jesd_sysref_lmfc;

  logic       coreclk;
  logic       rst_n;
  logic       sysref;
  logic       capture_en;
  logic       sysref_continuous;
  logic       err_clr;
  logic [7:0] lmfc_cnt;
  logic       lmfc_pulse;
  logic       aligned;
  logic       sysref_err;
  logic [7:0] sysref_edge_cnt;
`ifdef JESD_SYSREF_ERR_CNT_EN
  logic [7:0] sysref_err_cnt;
`endif

  int unsigned n_tests;
  int unsigned n_fail;

  jesd_sysref_lmfc #(
    .LMFC_PERIOD  (16),
    .CNT_W        (8),
    .SYNC_STAGES  (2),
    .SYSREF_OFFSET(0)
  ) dut (
    .coreclk          (coreclk),
    .rst_n            (rst_n),
    .sysref           (sysref),
    .capture_en       (capture_en),
    .sysref_continuous(sysref_continuous),
    .err_clr          (err_clr),
    .lmfc_cnt         (lmfc_cnt),
    .lmfc_pulse       (lmfc_pulse),
    .aligned          (aligned),
    .sysref_err       (sysref_err),
    .sysref_edge_cnt  (sysref_edge_cnt)
`ifdef JESD_SYSREF_ERR_CNT_EN
    ,
    .sysref_err_cnt   (sysref_err_cnt)
`endif
  );

  initial coreclk = 1'b0;
  always #5 coreclk = ~coreclk;

  task automatic tick();
    @(posedge coreclk);
    #1;
  endtask

  task automatic ticks(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) tick();
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic burst(input int unsigned n, input int unsigned half);
    for (int unsigned i = 0; i < n; i++) begin
      sysref = 1'b1;
      ticks(half);
      sysref = 1'b0;
      ticks(half);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_cnt"},     32'(lmfc_cnt),        0);
    check({tag, "_pulse"},   32'(lmfc_pulse),      0);
    check({tag, "_aligned"}, 32'(aligned),         0);
    check({tag, "_err"},     32'(sysref_err),      0);
    check({tag, "_edges"},   32'(sysref_edge_cnt), 0);
`ifdef JESD_SYSREF_ERR_CNT_EN
    check({tag, "_errcnt"},  32'(sysref_err_cnt),  0);
`endif
  endtask

  initial begin
    n_tests           = 0;
    n_fail            = 0;
    rst_n             = 1'b0;
    sysref            = 1'b0;
    capture_en        = 1'b0;
    sysref_continuous = 1'b0;
    err_clr           = 1'b0;

    ticks(3);
    check_all_zero("reset");

    // Free-running count after release: 1,2,..15,0,1..
    rst_n = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      tick();
      check("run_cnt",   32'(lmfc_cnt),   32'(i % 16));
      check("run_pulse", 32'(lmfc_pulse), 32'(i % 16 == 0));
    end

    // Arm, then SYSREF rise at relative cycle 0
    capture_en = 1'b1;
    ticks(2);
    sysref = 1'b1;
    ticks(3);
    check("armed_aligned", 32'(aligned),         0);
    check("armed_edges",   32'(sysref_edge_cnt), 0);
    tick();                                   // +4
    check("cap_cnt",     32'(lmfc_cnt),        0);
    check("cap_pulse",   32'(lmfc_pulse),      1);
    check("cap_aligned", 32'(aligned),         1);
    check("cap_err",     32'(sysref_err),      0);
    check("cap_edges",   32'(sysref_edge_cnt), 1);
    ticks(4);
    sysref = 1'b0;
    ticks(8);                                 // +16
    check("post_cap_cnt", 32'(lmfc_cnt), 12);

    // In-phase SYSREF every 16 cycles
    burst(2, 8);                              // +48
    check("inph_edges",   32'(sysref_edge_cnt), 3);
    check("inph_err",     32'(sysref_err),      0);
    check("inph_cnt",     32'(lmfc_cnt),        12);
    check("inph_aligned", 32'(aligned),         1);

    // +3 shifted edge, one-shot: error, phase kept
    ticks(3);
    sysref = 1'b1;
    ticks(4);                                 // +55
    check("mis1_err",     32'(sysref_err),      1);
    check("mis1_cnt",     32'(lmfc_cnt),        3);
    check("mis1_aligned", 32'(aligned),         1);
    check("mis1_edges",   32'(sysref_edge_cnt), 4);
    ticks(4);
    sysref = 1'b0;
    ticks(8);                                 // +67
    check("mis1_phase", 32'(lmfc_cnt), 15);

    // +3 shifted edge, continuous: error and reload
    sysref_continuous = 1'b1;
    sysref = 1'b1;
    ticks(4);                                 // +71
    check("mis2_cnt",     32'(lmfc_cnt),        0);
    check("mis2_pulse",   32'(lmfc_pulse),      1);
    check("mis2_err",     32'(sysref_err),      1);
    check("mis2_aligned", 32'(aligned),         1);
    check("mis2_edges",   32'(sysref_edge_cnt), 5);
`ifdef JESD_SYSREF_ERR_CNT_EN
    check("mis2_errcnt",  32'(sysref_err_cnt),  2);
`endif
    ticks(4);
    sysref = 1'b0;
    ticks(8);                                 // +83
    check("mis2_phase", 32'(lmfc_cnt), 12);

    // err_clr alone
    err_clr = 1'b1;
    tick();                                   // +84
    err_clr = 1'b0;
    check("clr_err", 32'(sysref_err), 0);
`ifdef JESD_SYSREF_ERR_CNT_EN
    check("clr_errcnt", 32'(sysref_err_cnt), 0);
`endif

    // err_clr coincident with a new misaligned edge
    ticks(2);
    sysref = 1'b1;
    ticks(3);                                 // +89
    check("pre_coinc_err", 32'(sysref_err), 0);
    check("pre_coinc_cnt", 32'(lmfc_cnt),   2);
    err_clr = 1'b1;
    tick();                                   // +90
    err_clr = 1'b0;
    check("coinc_err",   32'(sysref_err),      1);
    check("coinc_cnt",   32'(lmfc_cnt),        0);
    check("coinc_edges", 32'(sysref_edge_cnt), 6);
`ifdef JESD_SYSREF_ERR_CNT_EN
    check("coinc_errcnt", 32'(sysref_err_cnt), 1);
`endif
    sysref = 1'b0;
    ticks(8);                                 // +98
    check("coinc_phase", 32'(lmfc_cnt), 8);

    // capture_en drop coincident with a misaligned edge: no reload
    tick();
    sysref = 1'b1;
    ticks(3);                                 // +102
    check("drop_pre_aligned", 32'(aligned),  1);
    check("drop_pre_cnt",     32'(lmfc_cnt), 12);
    capture_en = 1'b0;
    tick();                                   // +103
    check("drop_aligned", 32'(aligned),         0);
    check("drop_cnt",     32'(lmfc_cnt),        13);
    check("drop_edges",   32'(sysref_edge_cnt), 7);
    check("drop_err",     32'(sysref_err),      1);
    tick();
    check("drop_cnt2",     32'(lmfc_cnt), 14);
    check("drop_aligned2", 32'(aligned),  0);
    sysref = 1'b0;
    ticks(8);

    // Edge counter saturation (edges counted in IDLE)
    burst(300, 8);
    check("sat_edges",   32'(sysref_edge_cnt), 255);
    check("sat_aligned", 32'(aligned),         0);
    check("sat_err",     32'(sysref_err),      1);
`ifdef JESD_SYSREF_ERR_CNT_EN
    check("sat_errcnt",  32'(sysref_err_cnt),  1);
`endif

    // Re-align, then asynchronous reset mid-run
    capture_en = 1'b1;
    ticks(2);
    sysref = 1'b1;
    ticks(4);
    check("realign_aligned", 32'(aligned),  1);
    check("realign_cnt",     32'(lmfc_cnt), 0);
    rst_n = 1'b0;
    #1;
    check_all_zero("async_rst");
    sysref     = 1'b0;
    capture_en = 1'b0;
    tick();
    check_all_zero("held_rst");
    rst_n = 1'b1;
    tick();
    check("rel_cnt",   32'(lmfc_cnt),   1);
    check("rel_pulse", 32'(lmfc_pulse), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
